// File: rtl/pc_gen.sv
// Program counter generator with a two-state RUN/HALT FSM and a circular
// return-address stack (RAS). next_pc is combinational; pc is registered,
// so a new pc appears one cycle after pc_op is sampled. All pc arithmetic
// wraps modulo 2^WIDTH.
module pc_gen #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STEP      = 4,
  parameter logic [63:0] RESET_VEC = 64'h0000_0000_0000_3000,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic [2:0]                     pc_op,
  input  logic [25:0]                    imm_j,
  input  logic [15:0]                    imm_i,
  input  logic [WIDTH-1:0]               jr_target,
  input  logic                           resume,
  output logic [WIDTH-1:0]               pc,
  output logic                           halted,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow,
  output logic                           bad_op
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [WIDTH-1:0] RST_PC   = RESET_VEC[WIDTH-1:0];
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [CW-1:0]    DEPTH_CW = CW'(RAS_DEPTH);

  localparam logic [2:0] OP_NEXT   = 3'b000;
  localparam logic [2:0] OP_IMM    = 3'b001;
  localparam logic [2:0] OP_OFFSET = 3'b010;
  localparam logic [2:0] OP_HALT   = 3'b011;
  localparam logic [2:0] OP_REG    = 3'b100;
  localparam logic [2:0] OP_CALL   = 3'b101;
  localparam logic [2:0] OP_RET    = 3'b110;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;
  logic             bad_reg, bad_next;
  logic             push, pop;

  // RAS storage: wr_ptr points at the slot the next CALL writes; the top
  // of stack is the slot just below it. Contents need no reset.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic [WIDTH-1:0] pc_step;
  logic [WIDTH-1:0] imm_target;
  logic [WIDTH-1:0] offset_ext;
  logic [WIDTH-1:0] reg_target;
  logic [WIDTH-1:0] ras_top;
  logic [PW-1:0]    top_idx;

  assign pc_step    = pc_reg + STEP_W;
  assign offset_ext = {{(WIDTH-18){imm_i[15]}}, imm_i, 2'b00};
  assign reg_target = {jr_target[WIDTH-1:2], 2'b00};
  assign top_idx    = wr_ptr_reg - PW'(1);
  assign ras_top    = ras_mem[top_idx];

  // J-type target keeps the pc's upper region only when WIDTH exceeds 28.
  generate
    if (WIDTH > 28) begin : g_imm_wide
      assign imm_target = {pc_reg[WIDTH-1:28], imm_j, 2'b00};
    end else begin : g_imm_narrow
      assign imm_target = {imm_j, 2'b00};
    end
  endgenerate

  // Next-state / next-pc decode; stall freezes everything and zeroes pulses.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    bad_next   = bad_reg;
    ovf_next   = 1'b0;
    unf_next   = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    if (!stall) begin
      case (state_reg)
        ST_RUN: begin
          case (pc_op)
            OP_NEXT:   pc_next = pc_step;
            OP_IMM:    pc_next = imm_target;
            OP_OFFSET: pc_next = pc_step + offset_ext;
            OP_HALT:   state_next = ST_HALT;
            OP_REG:    pc_next = reg_target;
            OP_CALL: begin
              pc_next  = imm_target;
              push     = 1'b1;
              ovf_next = (count_reg == DEPTH_CW);
            end
            OP_RET: begin
              if (count_reg != '0) begin
                pc_next = ras_top;
                pop     = 1'b1;
              end else begin
                pc_next  = pc_step;
                unf_next = 1'b1;
              end
            end
            default: begin
              pc_next  = pc_step;
              bad_next = 1'b1;
            end
          endcase
        end
        ST_HALT: begin
          if (resume) begin
            pc_next    = pc_step;
            state_next = ST_RUN;
          end
        end
        default: state_next = ST_RUN;
      endcase
    end
  end

  // RAS pointer and occupancy; a full stack keeps its count on CALL.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PW'(1);
      if (count_reg != DEPTH_CW) begin
        count_next = count_reg + CW'(1);
      end
    end else if (pop) begin
      wr_ptr_next = wr_ptr_reg - PW'(1);
      count_next  = count_reg - CW'(1);
    end
  end

  // Control and pc registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_RUN;
      pc_reg     <= RST_PC;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
      bad_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      count_reg  <= count_next;
      wr_ptr_reg <= wr_ptr_next;
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
      bad_reg    <= bad_next;
    end
  end

  // Return-address write on CALL; overwrites the oldest slot when full.
  always_ff @(posedge clk) begin
    if (push) begin
      ras_mem[wr_ptr_reg] <= pc_step;
    end
  end

  assign pc            = pc_reg;
  assign halted        = (state_reg == ST_HALT);
  assign ras_count     = count_reg;
  assign ras_overflow  = ovf_reg;
  assign ras_underflow = unf_reg;
  assign bad_op        = bad_reg;

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, 32, PC width in bits; legal range 28..64.
REQ-002 Parameter STEP, 4, sequential increment added to pc.
REQ-003 Parameter RESET_VEC, 32'h0000_3000, pc value loaded on reset; zero-extended or truncated to WIDTH.
REQ-004 Parameter RAS_DEPTH, 4, return-address-stack entries; power of two, minimum 2.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 stall  in  1  freezes all state when high.
REQ-008 pc_op  in  3  next-pc operation: 000 NEXT, 001 IMM_JMP, 010 OFFSET_JMP, 011 HALT, 100 REG_JMP, 101 CALL, 110 RET, 111 reserved.
REQ-009 imm_j  in  26  J-type immediate.
REQ-010 imm_i  in  16  I-type signed branch offset.
REQ-011 jr_target  in  WIDTH  register jump target.
REQ-012 resume  in  1  leaves the HALT state.
REQ-013 pc  out  WIDTH  registered program counter.
REQ-014 halted  out  1  high while the FSM is in HALT.
REQ-015 ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
REQ-016 ras_overflow  out  1  one-cycle pulse when a CALL overwrites the oldest entry.
REQ-017 ras_underflow  out  1  one-cycle pulse when a RET is issued with an empty RAS.
REQ-018 bad_op  out  1  sticky flag; set by reserved opcode 111.

Function
REQ-019 The FSM SHALL have two states, RUN and HALT; next_pc is combinational and pc is registered, so a new pc appears one cycle after pc_op is sampled.
REQ-020 Arithmetic SHALL be modulo 2^WIDTH, with pc_step = pc + STEP and wrap from all-ones to zero.
REQ-021 NEXT: next pc = pc_step.
REQ-022 IMM_JMP: next pc = {pc[WIDTH-1:28], imm_j, 2'b00}; when WIDTH = 28, next pc = {imm_j, 2'b00}.
REQ-023 OFFSET_JMP: next pc = pc_step + sign_extend({imm_i, 2'b00}) to WIDTH.
REQ-024 REG_JMP: next pc = {jr_target[WIDTH-1:2], 2'b00}; the low two bits are forced to zero.
REQ-025 CALL: jump exactly as IMM_JMP and push pc_step onto the RAS.
REQ-026 RET with ras_count > 0: next pc = top entry, the entry is popped, and ras_count decrements.
REQ-027 RET with ras_count = 0: next pc = pc_step and ras_underflow pulses for one cycle.
REQ-028 CALL with a full RAS: the RAS is circular, so the oldest entry is overwritten, ras_count stays at RAS_DEPTH, and ras_overflow pulses for one cycle.
REQ-029 Opcode 111 behaves as NEXT and sets bad_op, which stays set until reset.
REQ-030 HALT in RUN: pc holds, the FSM enters HALT, and halted rises on the next edge.
REQ-031 In HALT: pc_op is ignored, pc holds, and the RAS is unchanged.
REQ-032 resume in HALT: next pc = pc_step and the FSM returns to RUN.
REQ-033 resume in RUN SHALL be ignored.
REQ-034 stall high: pc, FSM state, RAS, ras_count and bad_op hold, the pulse outputs are 0, and resume is ignored; stall has priority over every opcode and over resume.
REQ-035 ras_overflow and ras_underflow SHALL be registered and asserted only in the cycle after the causing edge.

Reset
REQ-036 While rst_n is low, asynchronously: pc = RESET_VEC, state = RUN, halted = 0, ras_count = 0, ras_overflow = 0, ras_underflow = 0, bad_op = 0; RAS contents are don't-care.
REQ-037 Reset asserted mid-operation, including in HALT or during a stall, SHALL take effect immediately, without waiting for a clock edge.
REQ-038 The first edge after rst_n rises SHALL apply the pc_op sampled at that edge.

Verification
REQ-039 Reset, then 3 NEXT cycles -> pc = 3000, 3004, 3008, 300C.
REQ-040 pc = 3010, OFFSET_JMP with imm_i = FFFE -> pc = 300C; pc = FFFF_FFFC, NEXT -> pc = 0000_0000.
REQ-041 pc = 3000, CALL with imm_j = 0x100 -> pc = 0000_0400 and ras_count = 1; then RET -> pc = 3004 and ras_count = 0; then RET -> pc = 3008 and ras_underflow = 1 for one cycle.
REQ-042 Five CALLs with RAS_DEPTH = 4 -> ras_overflow pulses on the fifth and ras_count = 4; four RETs return the last four pushed addresses in LIFO order.
REQ-043 pc = 3020, HALT -> pc holds at 3020 and halted = 1 for 5 cycles despite IMM_JMP on pc_op; resume -> pc = 3024 and halted = 0; stall held high 3 cycles with REG_JMP -> pc unchanged.
REQ-044 rst_n pulsed low between clock edges while in HALT with ras_count = 2 -> pc = 3000, halted = 0 and ras_count = 0 before the next edge; opcode 111 afterwards -> bad_op = 1 and pc advances by 4.
